// File: rtl/singlecycle_pkg.sv
// Shared types and constants for the LCD command queue: FSM states, FIFO entry
// layout, LCD I/O register bit positions and the power-on init sequence.
package singlecycle_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        INIT  = 2'd3
    } lcd_q_state_e;

    typedef struct packed {
        logic       on;
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } lcd_q_entry_t;

    localparam int unsigned LCD_ON_BIT   = 31;
    localparam int unsigned LCD_RS_BIT   = 9;
    localparam int unsigned LCD_RW_BIT   = 8;
    localparam int unsigned LCD_DATA_LSB = 0;
    localparam int unsigned LCD_DATA_W   = 8;

    localparam int unsigned LCD_INIT_LEN = 4;
    localparam logic [7:0] LCD_INIT_SEQ [LCD_INIT_LEN] = '{8'h38, 8'h0C, 8'h06, 8'h01};

    // Clear and return-home need the long HD44780 execution time.
    function automatic logic lcd_is_long_cmd(input lcd_q_entry_t e);
        return !e.rs && !e.rw && ((e.data == 8'h01) || (e.data == 8'h02) || (e.data == 8'h03));
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; pushes while full and pops while empty
// are ignored. Flags, level and head data are combinational (_c).
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rdata_c,
    output logic                     o_full_c,
    output logic                     o_empty_c,
    output logic [$clog2(DEPTH):0]   o_level_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_wr;
    logic             w_rd;

    assign o_full_c  = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign o_empty_c = (r_wptr == r_rptr);
    assign o_level_c = r_wptr - r_rptr;
    assign o_rdata_c = r_mem[r_rptr[AW-1:0]];

    assign w_wr = i_push && !o_full_c;
    assign w_rd = i_pop && !o_empty_c;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_rd) r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/lcd_cmd_queue.sv
// Queues LCD words from the core and feeds lcd_ctrl one at a time, spacing them by
// the HD44780 execution time. LCD_QUEUE_INIT_EN adds a power-on init sequence.
module lcd_cmd_queue
    import singlecycle_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned T_PERIOD_NS = 40,
    parameter int unsigned T_CMD_US    = 40,
    parameter int unsigned T_CLR_US    = 1600
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_vld,
    input  logic [31:0]              i_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_ovf,
    output logic                     o_vld,
    input  logic                     i_rdy,
    output logic [7:0]               o_LCD_DATA,
    output logic                     o_LCD_RW,
    output logic                     o_LCD_RS,
    output logic                     o_LCD_ON,
    output logic                     o_busy
);

    localparam int unsigned N_CMD = T_CMD_US * 1000 / T_PERIOD_NS;
    localparam int unsigned N_CLR = T_CLR_US * 1000 / T_PERIOD_NS;
    localparam int unsigned CW    = $clog2(N_CLR) + 1;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
    localparam int unsigned EW    = $bits(lcd_q_entry_t);

`ifdef LCD_QUEUE_INIT_EN
    localparam lcd_q_state_e ST_RESET = INIT;
`else
    localparam lcd_q_state_e ST_RESET = IDLE;
`endif

    lcd_q_state_e  r_state;
    lcd_q_state_e  w_state_nxt;
    logic          r_vld;
    logic          w_vld_nxt;
    lcd_q_entry_t  r_head;
    lcd_q_entry_t  w_head_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_load;
    logic          r_on;
    logic          r_full;
    logic          r_empty;
    logic [LW-1:0] r_level;
    logic          r_ovf;
    logic          r_busy;

    logic          w_xfer;
    logic          w_load;
    logic          w_pop;
    logic          w_word_avail;
    lcd_q_entry_t  w_next_word;
    lcd_q_entry_t  w_in;
    lcd_q_entry_t  w_fifo_head;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [LW-1:0] w_fifo_level;
    logic          w_unused;

    assign w_in = {i_data[LCD_ON_BIT], i_data[LCD_RS_BIT], i_data[LCD_RW_BIT],
                   i_data[LCD_DATA_LSB +: LCD_DATA_W]};
    assign w_unused = ^{i_data[30:10]};

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_push    (i_vld),
        .i_wdata   (w_in),
        .i_pop     (w_pop),
        .o_rdata_c (w_fifo_head),
        .o_full_c  (w_fifo_full),
        .o_empty_c (w_fifo_empty),
        .o_level_c (w_fifo_level)
    );

`ifdef LCD_QUEUE_INIT_EN
    logic [1:0] r_init_idx;
    logic       r_init_pend;
    logic       r_from_init;

    // Init words take priority over the FIFO until the last one has transferred.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_init_idx  <= 2'd0;
            r_init_pend <= 1'b1;
            r_from_init <= 1'b0;
        end else begin
            if (w_load) r_from_init <= r_init_pend;
            if (w_xfer && r_from_init) begin
                r_init_idx <= r_init_idx + 2'd1;
                if (r_init_idx == 2'(LCD_INIT_LEN - 1)) r_init_pend <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next_word = w_fifo_head;
        if (r_init_pend) begin
            w_next_word.on   = 1'b1;
            w_next_word.rs   = 1'b0;
            w_next_word.rw   = 1'b0;
            w_next_word.data = LCD_INIT_SEQ[r_init_idx];
        end
    end

    assign w_word_avail = r_init_pend | ~w_fifo_empty;
    assign w_pop        = w_xfer & ~r_from_init;
`else
    assign w_next_word  = w_fifo_head;
    assign w_word_avail = ~w_fifo_empty;
    assign w_pop        = w_xfer;
`endif

    assign w_cnt_load = lcd_is_long_cmd(r_head) ? CW'(N_CLR - 1) : CW'(N_CMD - 1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_RESET;
        else       r_state <= w_state_nxt;
    end

    // Next state plus issue/wait datapath; w_load marks entry into ISSUE.
    always_comb begin
        w_state_nxt = r_state;
        w_vld_nxt   = r_vld;
        w_head_nxt  = r_head;
        w_cnt_nxt   = r_cnt;
        w_xfer      = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            IDLE, INIT: begin
                if (w_word_avail) w_load = 1'b1;
            end
            ISSUE: begin
                if (i_rdy) begin
                    w_xfer      = 1'b1;
                    w_vld_nxt   = 1'b0;
                    w_cnt_nxt   = w_cnt_load;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    if (w_word_avail) w_load = 1'b1;
                    else              w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_load) begin
            w_state_nxt = ISSUE;
            w_vld_nxt   = 1'b1;
            w_head_nxt  = w_next_word;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld   <= 1'b0;
            r_head  <= '0;
            r_cnt   <= '0;
            r_on    <= 1'b0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_level <= '0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_vld   <= w_vld_nxt;
            r_head  <= w_head_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_xfer) r_on <= r_head.on;
            r_full  <= w_fifo_full;
            r_empty <= w_fifo_empty;
            r_level <= w_fifo_level;
            r_ovf   <= r_ovf | (i_vld & w_fifo_full);
            // A push this edge makes the FIFO non-empty even if the FSM idles.
            r_busy  <= (w_state_nxt != IDLE) | ~w_fifo_empty | i_vld;
        end
    end

    assign o_vld      = r_vld;
    assign o_LCD_DATA = r_head.data;
    assign o_LCD_RW   = r_head.rw;
    assign o_LCD_RS   = r_head.rs;
    assign o_LCD_ON   = r_on;
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_level    = r_level;
    assign o_ovf      = r_ovf;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_lcd_cmd_queue.sv
// Directed bench for lcd_cmd_queue with DEPTH=4, N_CMD=25, N_CLR=100.
// Built with LCD_QUEUE_INIT_EN it checks the power-on init sequence instead.
module tb_lcd_cmd_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          vld;
    logic [31:0]   data;
    logic          rdy;
    logic          o_full;
    logic          o_empty;
    logic [LW-1:0] o_level;
    logic          o_ovf;
    logic          o_vld;
    logic [7:0]    o_LCD_DATA;
    logic          o_LCD_RW;
    logic          o_LCD_RS;
    logic          o_LCD_ON;
    logic          o_busy;

    lcd_cmd_queue #(
        .DEPTH       (4),
        .T_PERIOD_NS (40),
        .T_CMD_US    (1),
        .T_CLR_US    (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_vld      (vld),
        .i_data     (data),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_level    (o_level),
        .o_ovf      (o_ovf),
        .o_vld      (o_vld),
        .i_rdy      (rdy),
        .o_LCD_DATA (o_LCD_DATA),
        .o_LCD_RW   (o_LCD_RW),
        .o_LCD_RS   (o_LCD_RS),
        .o_LCD_ON   (o_LCD_ON),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Transfer words {RS,RW,DATA} and edge numbers, o_vld rises, o_busy falls.
    logic [9:0] xw [$];
    int         xe [$];
    int         re [$];
    int         bf [$];
    logic       pv = 1'b0;
    logic       pb = 1'b0;

    always @(negedge clk) begin
        if (o_vld && rdy) begin
            xw.push_back({o_LCD_RS, o_LCD_RW, o_LCD_DATA});
            xe.push_back(cyc + 1);
        end
        if (o_vld && !pv) re.push_back(cyc);
        if (!o_busy && pb) bf.push_back(cyc);
        pv = o_vld;
        pb = o_busy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] d, output int edge_n);
        vld  = 1'b1;
        data = d;
        tick();
        edge_n = cyc;
        vld  = 1'b0;
        data = 32'h0;
    endtask

    task automatic clrq();
        xw.delete();
        xe.delete();
        re.delete();
        bf.delete();
    endtask

    task automatic wait_x(input string tag, input int n, input int budget);
        for (int i = 0; i < budget && xw.size() < n; i++) tick();
        chk(tag, xw.size(), n);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget && o_busy; i++) tick();
        chk(tag, {31'd0, o_busy}, 32'd0);
        tick(2);
    endtask

    int  e0;
    int  e1;
    int  m;
    logic stable;

    initial begin
        rst  = 1'b1;
        vld  = 1'b0;
        data = 32'h0;
        rdy  = 1'b1;
        tick(3);
        chk("rst_vld",   {31'd0, o_vld},    32'd0);
        chk("rst_data",  {24'd0, o_LCD_DATA}, 32'd0);
        chk("rst_rw",    {31'd0, o_LCD_RW}, 32'd0);
        chk("rst_rs",    {31'd0, o_LCD_RS}, 32'd0);
        chk("rst_on",    {31'd0, o_LCD_ON}, 32'd0);
        chk("rst_full",  {31'd0, o_full},   32'd0);
        chk("rst_empty", {31'd0, o_empty},  32'd1);
        chk("rst_level", 32'(o_level),      32'd0);
        chk("rst_ovf",   {31'd0, o_ovf},    32'd0);
        chk("rst_busy",  {31'd0, o_busy},   32'd0);
        rst = 1'b0;

`ifdef LCD_QUEUE_INIT_EN
        clrq();
        push(32'h8000_0241, e0);
        wait_x("init_count", 5, 400);
        wait_idle("init_idle", 50);
        chk("init_total", xw.size(), 5);
        if (xw.size() >= 5) begin
            chk("init_w0", 32'(xw[0]), 32'({2'b00, 8'h38}));
            chk("init_w1", 32'(xw[1]), 32'({2'b00, 8'h0C}));
            chk("init_w2", 32'(xw[2]), 32'({2'b00, 8'h06}));
            chk("init_w3", 32'(xw[3]), 32'({2'b00, 8'h01}));
            chk("init_w4", 32'(xw[4]), 32'({2'b10, 8'h41}));
        end
        if (re.size() >= 5 && xe.size() >= 4) begin
            chk("init_gap_cmd", 32'(re[1] - xe[0]), 32'd25);
            chk("init_gap_clr", 32'(re[4] - xe[3]), 32'd100);
        end
        chk("init_on",    {31'd0, o_LCD_ON}, 32'd1);
        chk("init_empty", {31'd0, o_empty},  32'd1);
`else
        tick(2);

        // Single data write: latency, fields, ON latch, busy release.
        clrq();
        push(32'h8000_0241, e0);
        wait_x("t1_count", 1, 50);
        if (re.size() >= 1) chk("t1_latency", 32'(re[0] - e0), 32'd1);
        wait_idle("t1_idle", 60);
        if (xw.size() >= 1) chk("t1_word", 32'(xw[0]), 32'({2'b10, 8'h41}));
        chk("t1_on", {31'd0, o_LCD_ON}, 32'd1);
        if (bf.size() >= 1 && xe.size() >= 1) chk("t1_busy_fall", 32'(bf[0] - xe[0]), 32'd25);

        // Clear followed by data: long gap.
        clrq();
        push(32'h8000_0001, e0);
        push(32'h8000_0241, e1);
        wait_x("t2_count", 2, 200);
        if (xe.size() >= 1) chk("t2_first_edge", 32'(xe[0] - e0), 32'd2);
        if (re.size() >= 2 && xe.size() >= 1) chk("t2_gap", 32'(re[1] - xe[0]), 32'd100);
        if (xw.size() >= 2) begin
            chk("t2_w0", 32'(xw[0]), 32'({2'b00, 8'h01}));
            chk("t2_w1", 32'(xw[1]), 32'({2'b10, 8'h41}));
        end
        wait_idle("t2_idle", 60);

        // Overflow: five pushes into a 4-deep FIFO with lcd_ctrl stalled.
        clrq();
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) push(32'h8000_0010 + 32'(i), e0);
        tick(2);
        chk("t3_full",  {31'd0, o_full}, 32'd1);
        chk("t3_ovf",   {31'd0, o_ovf},  32'd1);
        chk("t3_level", 32'(o_level),    32'd4);
        chk("t3_vld",   {31'd0, o_vld},  32'd1);
        chk("t3_head",  {24'd0, o_LCD_DATA}, 32'h10);
        rdy = 1'b1;
        wait_x("t3_count", 4, 200);
        tick(40);
        chk("t3_total", xw.size(), 4);
        for (int i = 0; i < 4 && i < xw.size(); i++)
            chk($sformatf("t3_w%0d", i), 32'(xw[i]), 32'({2'b00, 8'h10 + 8'(i)}));
        wait_idle("t3_idle", 60);
        chk("t3_empty", {31'd0, o_empty}, 32'd1);

        // Stall with o_vld high: head held, no pop, transfer on first ready edge.
        clrq();
        rdy = 1'b0;
        push(32'h0000_0355, e0);
        tick(2);
        chk("t4_vld", {31'd0, o_vld}, 32'd1);
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if ({o_vld, o_LCD_RS, o_LCD_RW, o_LCD_DATA} !== {1'b1, 1'b1, 1'b1, 8'h55}) stable = 1'b0;
            tick();
        end
        chk("t4_stable", {31'd0, stable}, 32'd1);
        chk("t4_level", 32'(o_level), 32'd1);
        chk("t4_no_xfer", xw.size(), 0);
        m   = cyc;
        rdy = 1'b1;
        wait_x("t4_count", 1, 5);
        if (xe.size() >= 1) chk("t4_edge", 32'(xe[0] - m), 32'd1);
        if (xw.size() >= 1) chk("t4_word", 32'(xw[0]), 32'({2'b11, 8'h55}));
        wait_idle("t4_idle", 60);
        chk("t4_on", {31'd0, o_LCD_ON}, 32'd0);

        // Reset in WAIT with two entries queued clears everything at once.
        clrq();
        push(32'h8000_0020, e0);
        push(32'h8000_0021, e0);
        push(32'h8000_0022, e0);
        tick(3);
        chk("t5_level_pre", 32'(o_level), 32'd2);
        chk("t5_ovf_sticky", {31'd0, o_ovf}, 32'd1);
        chk("t5_busy_pre", {31'd0, o_busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_vld",   {31'd0, o_vld},   32'd0);
        chk("t5_empty", {31'd0, o_empty}, 32'd1);
        chk("t5_level", 32'(o_level),     32'd0);
        chk("t5_ovf",   {31'd0, o_ovf},   32'd0);
        chk("t5_busy",  {31'd0, o_busy},  32'd0);
        tick();
        rst = 1'b0;
        clrq();
        tick(60);
        chk("t5_no_rise", re.size(), 0);
        chk("t5_no_xfer", xw.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
